// File: rtl/csr_irq_ctrl.sv
// -----------------------------------------------------------------------------
// csr_irq_ctrl
//   Machine-mode CSR file and interrupt controller for the RV32 core, placed
//   beside the EX stage. Holds mstatus/mie/mip/mtvec/mepc/mcause plus the
//   mcycle/minstret counters. Arbitrates external, timer and platform-local
//   interrupt lines by fixed priority and computes direct or vectored trap
//   entry. Also provides WFI stall and wake.
//
// Ports
//   clk          core clock
//   rst          asynchronous active-low reset
//   pipe_stall   pipeline stall; freezes architectural updates except mcycle
//   csr_en       CSR instruction valid in EX
//   csr_funct3   001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   csr_addr     CSR address
//   csr_wdata    rs1 value or zero-extended zimm (already muxed)
//   csr_rdata    pre-write CSR value (combinational)
//   csr_illegal  csr_en to an unimplemented address (combinational)
//   mret         MRET valid in EX
//   wfi          WFI valid in EX
//   instr_retire one instruction retires this cycle
//   pc           PC of the EX instruction (trap return point)
//   timer_irq    timer level        -> mip bit 7
//   ext_irq      external level     -> mip bit 11
//   local_irq    local level lines  -> mip bits 16+i
//   trap_take    redirect fetch to trap_pc this cycle (combinational)
//   trap_pc      trap entry address
//   ret_pc       mepc, used on mret
//   wfi_stall    hold the pipeline while waiting for an interrupt (registered)
// -----------------------------------------------------------------------------
module csr_irq_ctrl #(
    parameter int unsigned NUM_LOCAL   = 2,
    parameter logic [31:0] RESET_MTVEC = 32'h0001_0000,
    parameter int unsigned CNT_W       = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     pipe_stall,
    input  logic                                     csr_en,
    input  logic [2:0]                               csr_funct3,
    input  logic [11:0]                              csr_addr,
    input  logic [31:0]                              csr_wdata,
    output logic [31:0]                              csr_rdata,
    output logic                                     csr_illegal,
    input  logic                                     mret,
    input  logic                                     wfi,
    input  logic                                     instr_retire,
    input  logic [31:0]                              pc,
    input  logic                                     timer_irq,
    input  logic                                     ext_irq,
    input  logic [((NUM_LOCAL > 0) ? NUM_LOCAL : 1)-1:0] local_irq,
    output logic                                     trap_take,
    output logic [31:0]                              trap_pc,
    output logic [31:0]                              ret_pc,
    output logic                                     wfi_stall
);

    // CSR addresses
    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    // Writable-bit masks; every bit outside a mask reads as zero.
    localparam logic [31:0] MIE_LOCAL_MASK = ((32'd1 << NUM_LOCAL) - 32'd1) << 16;
    localparam logic [31:0] MIE_MASK       = 32'h0000_0880 | MIE_LOCAL_MASK;
    localparam logic [31:0] MTVEC_MASK     = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_MASK      = 32'hFFFF_FFFC;
    localparam logic [31:0] MCAUSE_MASK    = 32'h8000_001F;

    // Next value of a split counter. A write to either half replaces that
    // half and suppresses the increment for the cycle.
    function automatic logic [63:0] cnt_next(
        input logic [63:0] cur,
        input logic        wr_lo,
        input logic        wr_hi,
        input logic [31:0] wval,
        input logic        inc
    );
        logic [63:0] nxt;
        if (wr_lo) begin
            nxt = {cur[63:32], wval};
        end else if (wr_hi) begin
            nxt = {wval, cur[31:0]};
        end else if (inc) begin
            nxt = cur + 64'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Architectural state
    logic                 mstatus_mie_r;
    logic                 mstatus_mpie_r;
    logic [31:0]          mie_r;
    logic [31:0]          mtvec_r;
    logic [31:0]          mepc_r;
    logic [31:0]          mcause_r;
    logic [CNT_W-1:0]     mcycle_r;
    logic [CNT_W-1:0]     minstret_r;
    logic                 wfi_stall_r;

    // Combinational helpers
    logic [31:0]          mip_s;
    logic [31:0]          pend_s;
    logic                 pend_any_s;
    logic [4:0]           local_cause_s;
    logic                 local_hit_s;
    logic [4:0]           irq_cause_s;
    logic                 trap_take_s;
    logic [31:0]          trap_base_s;
    logic [31:0]          trap_pc_s;
    logic [63:0]          mcycle_ext_s;
    logic [63:0]          minstret_ext_s;
    logic [31:0]          rdata_s;
    logic                 addr_valid_s;
    logic [31:0]          wval_s;
    logic                 wr_req_s;
    logic                 csr_wr_s;
    logic                 mret_commit_s;
    logic                 instret_inc_s;

    assign mcycle_ext_s   = 64'(mcycle_r);
    assign minstret_ext_s = 64'(minstret_r);

    // Live interrupt-pending image; the lines are levels and are not latched.
    always_comb begin
        mip_s     = 32'd0;
        mip_s[7]  = timer_irq;
        mip_s[11] = ext_irq;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            mip_s[16+i] = local_irq[i];
        end
    end

    assign pend_s     = mip_s & mie_r;
    assign pend_any_s = |pend_s;

    // Lowest-numbered pending local line wins among the locals.
    always_comb begin
        local_cause_s = 5'd0;
        local_hit_s   = 1'b0;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            local_cause_s = (!local_hit_s && pend_s[16+i]) ? 5'(16 + i) : local_cause_s;
            local_hit_s   = local_hit_s | pend_s[16+i];
        end
    end

    // Fixed priority: external, then timer, then locals.
    always_comb begin
        if (pend_s[11]) begin
            irq_cause_s = 5'd11;
        end else if (pend_s[7]) begin
            irq_cause_s = 5'd7;
        end else begin
            irq_cause_s = local_cause_s;
        end
    end

    assign trap_take_s = mstatus_mie_r & pend_any_s & ~pipe_stall;
    assign trap_base_s = {mtvec_r[31:2], 2'b00};

    // Vectored mode offsets the base by four bytes per cause number.
    always_comb begin
        if (mtvec_r[0]) begin
            trap_pc_s = trap_base_s + {25'd0, irq_cause_s, 2'b00};
        end else begin
            trap_pc_s = trap_base_s;
        end
    end

    // CSR read mux and address decode.
    always_comb begin
        rdata_s      = 32'd0;
        addr_valid_s = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:   rdata_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
            ADDR_MIE:       rdata_s = mie_r;
            ADDR_MTVEC:     rdata_s = mtvec_r;
            ADDR_MEPC:      rdata_s = mepc_r;
            ADDR_MCAUSE:    rdata_s = mcause_r;
            ADDR_MIP:       rdata_s = mip_s;
            ADDR_MCYCLE:    rdata_s = mcycle_ext_s[31:0];
            ADDR_MCYCLEH:   rdata_s = mcycle_ext_s[63:32];
            ADDR_MINSTRET:  rdata_s = minstret_ext_s[31:0];
            ADDR_MINSTRETH: rdata_s = minstret_ext_s[63:32];
            default: begin
                rdata_s      = 32'd0;
                addr_valid_s = 1'b0;
            end
        endcase
    end

    // Write value per operation; set/clear with a zero operand never writes.
    always_comb begin
        case (csr_funct3)
            3'b001, 3'b101: begin
                wval_s   = csr_wdata;
                wr_req_s = 1'b1;
            end
            3'b010, 3'b110: begin
                wval_s   = rdata_s | csr_wdata;
                wr_req_s = (csr_wdata != 32'd0);
            end
            3'b011, 3'b111: begin
                wval_s   = rdata_s & ~csr_wdata;
                wr_req_s = (csr_wdata != 32'd0);
            end
            default: begin
                wval_s   = rdata_s;
                wr_req_s = 1'b0;
            end
        endcase
    end

    // A trap beats mret, which beats a CSR write; the loser is re-executed.
    assign mret_commit_s = mret & ~pipe_stall & ~trap_take_s;
    assign csr_wr_s      = csr_en & ~pipe_stall & ~trap_take_s & ~mret & wr_req_s
                           & addr_valid_s & (csr_addr != ADDR_MIP);
    assign instret_inc_s = instr_retire & ~pipe_stall;

    // Trap entry, mret and CSR writes to mstatus/mepc/mcause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mepc_r         <= 32'd0;
            mcause_r       <= 32'd0;
        end else if (trap_take_s) begin
            mepc_r         <= pc & MEPC_MASK;
            mcause_r       <= {1'b1, 26'd0, irq_cause_s};
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (mret_commit_s) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (csr_wr_s) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_r  <= wval_s[3];
                    mstatus_mpie_r <= wval_s[7];
                end
                ADDR_MEPC:   mepc_r   <= wval_s & MEPC_MASK;
                ADDR_MCAUSE: mcause_r <= wval_s & MCAUSE_MASK;
                default: begin
                    mepc_r   <= mepc_r;
                    mcause_r <= mcause_r;
                end
            endcase
        end else begin
            mstatus_mie_r  <= mstatus_mie_r;
            mstatus_mpie_r <= mstatus_mpie_r;
        end
    end

    // CSR writes to mie and mtvec.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_r   <= 32'd0;
            mtvec_r <= RESET_MTVEC;
        end else if (csr_wr_s && (csr_addr == ADDR_MIE)) begin
            mie_r <= wval_s & MIE_MASK;
        end else if (csr_wr_s && (csr_addr == ADDR_MTVEC)) begin
            mtvec_r <= wval_s & MTVEC_MASK;
        end else begin
            mie_r   <= mie_r;
            mtvec_r <= mtvec_r;
        end
    end

    // mcycle runs through stalls; minstret counts unstalled retirements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_r   <= {CNT_W{1'b0}};
            minstret_r <= {CNT_W{1'b0}};
        end else begin
            mcycle_r   <= CNT_W'(cnt_next(mcycle_ext_s,
                                          csr_wr_s && (csr_addr == ADDR_MCYCLE),
                                          csr_wr_s && (csr_addr == ADDR_MCYCLEH),
                                          wval_s, 1'b1));
            minstret_r <= CNT_W'(cnt_next(minstret_ext_s,
                                          csr_wr_s && (csr_addr == ADDR_MINSTRET),
                                          csr_wr_s && (csr_addr == ADDR_MINSTRETH),
                                          wval_s, instret_inc_s));
        end
    end

    // WFI wake ignores mstatus.MIE: any enabled pending line releases the stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wfi_stall_r <= 1'b0;
        end else if (pend_any_s) begin
            wfi_stall_r <= 1'b0;
        end else if (wfi && !pipe_stall) begin
            wfi_stall_r <= 1'b1;
        end else begin
            wfi_stall_r <= wfi_stall_r;
        end
    end

    assign csr_rdata   = rdata_s;
    assign csr_illegal = csr_en & ~addr_valid_s;
    assign trap_take   = trap_take_s;
    assign trap_pc     = trap_pc_s;
    assign ret_pc      = mepc_r;
    assign wfi_stall   = wfi_stall_r;

endmodule
